// File: rtl/sw_alloc_if.sv
// Request/grant bundle between the input channels of one output port and its switch allocator.
// The allocator side uses the slave modport; the channel/crossbar side uses master.
interface sw_alloc_if #(
  parameter int PORTS = 5,
  parameter int PORTW = 2
);
  logic [PORTS-1:0] req;
  logic [PORTS-1:0] ivalid;
  logic [PORTS-1:0] itail;
  logic             irdy;
  logic [PORTS-1:0] grt;
  logic [PORTW:0]   sel;
  logic             busy;

  modport master (
    output req, ivalid, itail, irdy,
    input  grt, sel, busy
  );

  modport slave (
    input  req, ivalid, itail, irdy,
    output grt, sel, busy
  );
endinterface

// File: rtl/sw_alloc.sv
// Per-output-port switch allocator: locks the port to one input for a whole packet, then rotates.
// Build option SA_FIXED_PRIO_EN: lowest-index requester always wins instead of round-robin.
//
// state  | meaning
// IDLE   | no packet owns the port; any request is arbitrated from ptr+1
// LOCKED | port owned by input sel until its tail transfers or it drops req
module sw_alloc #(
  parameter int PORTS = 5,
  parameter int PORTW = 2
) (
  input  logic       clk,
  input  logic       rst_,
  sw_alloc_if.slave  bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [PORTW:0] LAST = (PORTW+1)'(PORTS-1);

  state_t           state, state_nx;
  logic [PORTS-1:0] grt_q, grt_nx;
  logic [PORTW:0]   sel_q, sel_nx;
  logic [PORTW:0]   ptr_q, ptr_nx;
  logic             busy_q, busy_nx;

  logic             fire;
  logic             rel;
  logic [PORTS-1:0] cand;
  logic [PORTW:0]   start;
  logic             win_ok;
  logic [PORTW:0]   win;
  logic [PORTW+1:0] idx;

  function automatic logic [PORTW:0] wrap_inc(input logic [PORTW:0] v);
    return (v == LAST) ? '0 : v + 1'b1;
  endfunction

  assign fire = busy_q & (|(grt_q & bus.ivalid)) & bus.irdy;
  assign rel  = busy_q & ((fire & bus.itail[sel_q]) | ~bus.req[sel_q]);

  // The current owner is masked out so it cannot re-win in its own release cycle.
  always_comb begin
    cand  = '0;
    start = '0;
    if (state == IDLE) begin
      cand = bus.req;
    end else begin
      cand = bus.req & ~grt_q;
    end
`ifdef SA_FIXED_PRIO_EN
    start = '0;
`else
    start = (state == IDLE) ? wrap_inc(ptr_q) : wrap_inc(sel_q);
`endif
  end

  always_comb begin
    win_ok = 1'b0;
    win    = '0;
    idx    = '0;
    for (int i = 0; i < PORTS; i++) begin
      idx = {1'b0, start} + (PORTW+2)'(i);
      if (idx >= (PORTW+2)'(PORTS)) begin
        idx = idx - (PORTW+2)'(PORTS);
      end
      if (!win_ok && cand[idx[PORTW:0]]) begin
        win_ok = 1'b1;
        win    = idx[PORTW:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state  <= IDLE;
      grt_q  <= '0;
      sel_q  <= '0;
      ptr_q  <= LAST;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      grt_q  <= grt_nx;
      sel_q  <= sel_nx;
      ptr_q  <= ptr_nx;
      busy_q <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grt_nx   = grt_q;
    sel_nx   = sel_q;
    ptr_nx   = ptr_q;
    busy_nx  = busy_q;
    case (state)
      IDLE: begin
        grt_nx  = '0;
        busy_nx = 1'b0;
        if (win_ok) begin
          grt_nx   = PORTS'(1) << win;
          sel_nx   = win;
          ptr_nx   = win;
          busy_nx  = 1'b1;
          state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (rel) begin
          if (win_ok) begin
            grt_nx = PORTS'(1) << win;
            sel_nx = win;
            ptr_nx = win;
          end else begin
            grt_nx   = '0;
            sel_nx   = '0;
            busy_nx  = 1'b0;
            state_nx = IDLE;
          end
        end
      end
      default: begin
        grt_nx   = '0;
        sel_nx   = '0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.grt  = grt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_sw_alloc.sv
// Self-checking bench for sw_alloc: directed packet scenarios plus random traffic
// compared against an owner/pointer reference model.
module tb_sw_alloc;

`ifdef SA_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ = 1'b1;

  sw_alloc_if bus ();

  sw_alloc dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: which input owns the port (-1 = none) and last winner
  int owner   = -1;
  int last    = 4;
  int owner_n = -1;
  int last_n  = 4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [4:0] c, input int st);
    for (int k = 0; k < 5; k++) begin
      if (c[(st + k) % 5]) return (st + k) % 5;
    end
    return -1;
  endfunction

  task automatic model_next();
    logic [4:0] oth;
    bit f;
    bit r;
    owner_n = owner;
    last_n  = last;
    if (owner < 0) begin
      if (bus.req != 5'b0) begin
        owner_n = pick(bus.req, FIXED ? 0 : (last + 1) % 5);
        last_n  = owner_n;
      end
    end else begin
      f = bus.ivalid[owner] && bus.irdy;
      r = (f && bus.itail[owner]) || !bus.req[owner];
      if (r) begin
        oth = bus.req;
        oth[owner] = 1'b0;
        if (oth != 5'b0) begin
          owner_n = pick(oth, FIXED ? 0 : (owner + 1) % 5);
          last_n  = owner_n;
        end else begin
          owner_n = -1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] eg;
    eg = (owner < 0) ? 32'd0 : (32'd1 << owner);
    chk({tag, ".grt"}, 32'(bus.grt), eg);
    chk({tag, ".busy"}, 32'(bus.busy), (owner >= 0) ? 32'd1 : 32'd0);
    if (owner >= 0) chk({tag, ".sel"}, 32'(bus.sel), 32'(owner));
    chk({tag, ".onehot"}, ($countones(bus.grt) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // inputs are already driven; advance one edge and compare against the model
  task automatic step(input string tag);
    model_next();
    @(posedge clk);
    #1;
    owner = owner_n;
    last  = last_n;
    check_model(tag);
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] v, input logic [4:0] t, input logic rdy);
    bus.req    = r;
    bus.ivalid = v;
    bus.itail  = t;
    bus.irdy   = rdy;
  endtask

  task automatic do_reset(input string tag);
    rst_ = 1'b1;
    #1;
    rst_ = 1'b0;
    #2;
    owner = -1;
    last  = 4;
    chk({tag, ".rst_grt"}, 32'(bus.grt), 32'd0);
    chk({tag, ".rst_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".rst_sel"}, 32'(bus.sel), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] exp_seq [6];
    drive(5'b0, 5'b0, 5'b0, 1'b0);

    // 3-flit packet from input 2
    do_reset("t1");
    drive(5'b00100, 5'b00100, 5'b00000, 1'b1);
    step("t1.head");
    chk("t1.grt_head", 32'(bus.grt), 32'h04);
    chk("t1.sel_head", 32'(bus.sel), 32'd2);
    step("t1.f1");
    chk("t1.grt_f1", 32'(bus.grt), 32'h04);
    step("t1.f2");
    drive(5'b00100, 5'b00100, 5'b00100, 1'b1);
    step("t1.tail");
    chk("t1.busy_after_tail", 32'(bus.busy), 32'd0);
    drive(5'b0, 5'b0, 5'b0, 1'b1);
    step("t1.idle");

    // all requesting, single-flit packets
    do_reset("t2");
    if (FIXED) begin
      exp_seq = '{5'b00001, 5'b00010, 5'b00001, 5'b00010, 5'b00001, 5'b00010};
    end else begin
      exp_seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    end
    drive(5'b11111, 5'b11111, 5'b11111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step("t2.rr");
      chk($sformatf("t2.seq%0d", i), 32'(bus.grt), 32'(exp_seq[i]));
    end

    // stalled tail on input 1 while input 3 waits
    do_reset("t3");
    drive(5'b00010, 5'b00010, 5'b00010, 1'b0);
    step("t3.lock");
    drive(5'b01010, 5'b01010, 5'b01010, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step("t3.stall");
      chk("t3.grt_held", 32'(bus.grt), 32'h02);
    end
    bus.irdy = 1'b1;
    step("t3.fire");
    chk("t3.grt_next", 32'(bus.grt), 32'h08);

    // abort: input 0 drops req mid-packet, input 2 pending
    do_reset("t4");
    drive(5'b00101, 5'b00001, 5'b00000, 1'b1);
    step("t4.lock");
    chk("t4.grt_lock", 32'(bus.grt), 32'h01);
    step("t4.hold");
    chk("t4.ignored", 32'(bus.grt), 32'h01);
    drive(5'b00100, 5'b00100, 5'b00000, 1'b1);
    step("t4.abort");
    chk("t4.grt0_off", 32'(bus.grt[0]), 32'd0);
    chk("t4.grt_new", 32'(bus.grt), 32'h04);

    // async reset while locked to input 3
    do_reset("t5");
    drive(5'b01000, 5'b01000, 5'b00000, 1'b1);
    step("t5.lock");
    step("t5.flit");
    chk("t5.grt_locked", 32'(bus.grt), 32'h08);
    #2;
    rst_ = 1'b0;
    #1;
    owner = -1;
    last  = 4;
    chk("t5.async_grt", 32'(bus.grt), 32'd0);
    chk("t5.async_busy", 32'(bus.busy), 32'd0);
    drive(5'b11000, 5'b11000, 5'b00000, 1'b1);
    @(negedge clk);
    rst_ = 1'b1;
    step("t5.after");
    chk("t5.grt_after", 32'(bus.grt), 32'h08);

    // input 4 re-requests right after its single-flit packet; input 2 must win
    do_reset("t6");
    drive(5'b10000, 5'b10000, 5'b10000, 1'b0);
    step("t6.lock");
    drive(5'b10100, 5'b10100, 5'b10100, 1'b1);
    step("t6.release");
    chk("t6.grt_next", 32'(bus.grt), 32'h04);

    // random traffic against the model
    do_reset("rnd");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 5'($urandom);
      bus.ivalid = 5'($urandom);
      bus.itail  = 5'($urandom);
      bus.irdy   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd");
      end
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
